// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
// Carries the request and response signals of alu_exec_unit.
//   master : requester side. It drives in_valid, ALUOp, funct, a, b and shamt.
//            It samples in_ready, out_valid, result, zero, hi and lo.
//   slave  : execution unit side. It has the opposite directions.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, ALUOp, funct, a, b, shamt,
        input  in_ready, out_valid, result, zero, hi, lo
    );

    modport slave (
        input  in_valid, ALUOp, funct, a, b, shamt,
        output in_ready, out_valid, result, zero, hi, lo
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// MIPS-style execution unit.
// Single-cycle ALU operations return their result one cycle after they are accepted.
// mult/multu and div/divu run as WIDTH-iteration sequential operations and write HI/LO.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_exec_unit_if.slave, the request/response bundle
//
// state | meaning
// IDLE  | accepting requests; single-cycle ops complete from here
// MUL   | shift-add multiply of operand magnitudes, one bit per cycle
// DIV   | restoring divide of operand magnitudes, one bit per cycle
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_nx;

    logic             in_ready_c;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Iteration down-counter: it reaches zero on the last iteration.
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   a_raw;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic accept, is_r, is_mul, is_div, sgn_op;
    logic [WIDTH-1:0] mag_a, mag_b, alu_res;

    assign accept = bus.in_valid && in_ready_c;
    assign is_r   = (bus.ALUOp == 2'b10);
    assign is_mul = is_r && (bus.funct == F_MULT || bus.funct == F_MULTU);
    assign is_div = is_r && (bus.funct == F_DIV  || bus.funct == F_DIVU);
    assign sgn_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    assign mag_a  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_comb begin
        alu_res = bus.a & bus.b;
        case (bus.ALUOp)
            2'b00: alu_res = bus.a + bus.b;
            2'b01: alu_res = bus.a - bus.b;
            2'b10: begin
                case (bus.funct)
                    F_ADD:  alu_res = bus.a + bus.b;
                    F_SUB:  alu_res = bus.a - bus.b;
                    F_AND:  alu_res = bus.a & bus.b;
                    F_OR:   alu_res = bus.a | bus.b;
                    F_XOR:  alu_res = bus.a ^ bus.b;
                    F_NOR:  alu_res = ~(bus.a | bus.b);
                    F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                    F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                    F_SLL:  alu_res = bus.b << bus.shamt;
                    F_SRL:  alu_res = bus.b >> bus.shamt;
                    F_SRA:  alu_res = $unsigned($signed(bus.b) >>> bus.shamt);
                    F_MFHI: alu_res = hi_q;
                    F_MFLO: alu_res = lo_q;
                    default: alu_res = bus.a & bus.b;
                endcase
            end
            default: alu_res = bus.a & bus.b;
        endcase
    end

    // One multiply step. The low half of prod holds the remaining multiplier bits.
    // The high half accumulates the partial product.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nx, prod_fin;
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign prod_nx  = {mul_sum, prod[WIDTH-1:1]};
    assign prod_fin = neg_q ? -prod_nx : prod_nx;

    // One restoring-divide step. The partial remainder stays below the divisor.
    // Because of that, the difference always fits in WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, rem_nx, quo_nx, rem_fin, quo_fin;
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign div_diff  = div_shift[WIDTH-1:0] - opb;
    assign rem_nx    = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign quo_nx    = {quo[WIDTH-2:0], div_ge};
    assign quo_fin   = div0 ? {WIDTH{1'b1}} : (neg_q ? -quo_nx : quo_nx);
    assign rem_fin   = div0 ? a_raw : (neg_r ? -rem_nx : rem_nx);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)      state_nx = MUL;
                else if (accept && is_div) state_nx = DIV;
            end
            MUL:     if (cnt == '0) state_nx = IDLE;
            DIV:     if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        if (state == IDLE && !reset) in_ready_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt         <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            cnt   <= SHW'(WIDTH-1);
                            prod  <= {{WIDTH{1'b0}}, mag_a};
                            opb   <= mag_b;
                            rem   <= '0;
                            quo   <= mag_a;
                            a_raw <= bus.a;
                            neg_q <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r <= sgn_op && bus.a[WIDTH-1];
                            div0  <= (bus.b == '0);
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                        end
                    end
                end
                MUL: begin
                    prod <= prod_nx;
                    if (cnt == '0) begin
                        hi_q        <= prod_fin[2*WIDTH-1:WIDTH];
                        lo_q        <= prod_fin[WIDTH-1:0];
                        result_q    <= prod_fin[WIDTH-1:0];
                        zero_q      <= (prod_fin[WIDTH-1:0] == '0);
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == '0) begin
                        hi_q        <= rem_fin;
                        lo_q        <= quo_fin;
                        result_q    <= quo_fin;
                        zero_q      <= (quo_fin == '0);
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed bench for alu_exec_unit.
// It instantiates one 32-bit unit and one 8-bit unit.
// Both units share clk and reset.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_exec_unit_if #(.WIDTH(32)) bus32();
    alu_exec_unit_if #(.WIDTH(8))  bus8();

    alu_exec_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_exec_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic ov(input bit w8);
        return w8 ? bus8.out_valid : bus32.out_valid;
    endfunction

    function automatic logic rdy(input bit w8);
        return w8 ? bus8.in_ready : bus32.in_ready;
    endfunction

    function automatic logic [63:0] res(input bit w8);
        return w8 ? {56'b0, bus8.result} : {32'b0, bus32.result};
    endfunction

    function automatic logic [63:0] hilo(input bit w8);
        return w8 ? {48'b0, bus8.hi, bus8.lo} : {bus32.hi, bus32.lo};
    endfunction

    task automatic drive(input bit w8, input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [63:0] av, input logic [63:0] bv, input logic [5:0] sh);
        if (w8) begin
            bus8.in_valid = v; bus8.ALUOp = op; bus8.funct = fn;
            bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.shamt = sh[2:0];
        end else begin
            bus32.in_valid = v; bus32.ALUOp = op; bus32.funct = fn;
            bus32.a = av[31:0]; bus32.b = bv[31:0]; bus32.shamt = sh[4:0];
        end
    endtask

    task automatic issue(input bit w8, input logic [1:0] op, input logic [5:0] fn,
                         input logic [63:0] av, input logic [63:0] bv, input logic [5:0] sh);
        @(negedge clk);
        drive(w8, 1'b1, op, fn, av, bv, sh);
        @(posedge clk); #1;
        bus8.in_valid  = 1'b0;
        bus32.in_valid = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [1:0] op, input logic [5:0] fn,
                           input logic [63:0] av, input logic [63:0] bv, input logic [5:0] sh,
                           input logic [31:0] exp);
        issue(1'b0, op, fn, av, bv, sh);
        chk({tag, ".valid"}, ov(1'b0), 1'b1);
        chk({tag, ".result"}, res(1'b0), exp);
        chk({tag, ".zero"}, bus32.zero, exp == 32'd0);
    endtask

    // Issues a multi-cycle op and then offers a junk request while the unit is busy.
    // It checks the latency, the busy window, HI/LO and result.
    task automatic run_mdu(input string tag, input bit w8, input logic [5:0] fn,
                           input logic [63:0] av, input logic [63:0] bv,
                           input int width, input logic [63:0] exp_hilo);
        int cyc, low;
        logic [63:0] lomask;
        issue(w8, 2'b10, fn, av, bv, 6'd0);
        drive(w8, 1'b1, 2'b00, 6'd0, 64'd1, 64'd1, 6'd0);
        cyc = 0;
        low = 0;
        while (!ov(w8) && cyc < 200) begin
            if (!rdy(w8)) low++;
            if (cyc == 4) drive(w8, 1'b0, 2'b00, 6'd0, 64'd0, 64'd0, 6'd0);
            @(posedge clk); #1;
            cyc++;
        end
        drive(w8, 1'b0, 2'b00, 6'd0, 64'd0, 64'd0, 6'd0);
        lomask = w8 ? 64'hFF : 64'hFFFF_FFFF;
        chk({tag, ".latency"}, 64'(cyc), 64'(width));
        chk({tag, ".busy"}, 64'(low), 64'(width));
        chk({tag, ".ready_after"}, rdy(w8), 1'b1);
        chk({tag, ".hilo"}, hilo(w8), exp_hilo);
        chk({tag, ".result"}, res(w8), exp_hilo & lomask);
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] av;
        logic [31:0] bv;
        logic [5:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        drive(1'b0, 1'b0, 2'b00, 6'd0, 64'd0, 64'd0, 6'd0);
        drive(1'b1, 1'b0, 2'b00, 6'd0, 64'd0, 64'd0, 6'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", bus32.in_ready, 1'b0);
        chk("rst.valid", bus32.out_valid, 1'b0);
        chk("rst.result", bus32.result, 32'd0);
        chk("rst.zero", bus32.zero, 1'b1);
        chk("rst.hilo", hilo(1'b0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst.ready_after", bus32.in_ready, 1'b1);

        vecs.push_back('{"add",   2'b00, 6'b000000, 32'hFFFF_FFFF, 32'h2,         6'd0,  32'h1});
        vecs.push_back('{"sub",   2'b01, 6'b000000, 32'h3,         32'h5,         6'd0,  32'hFFFF_FFFE});
        vecs.push_back('{"rsv",   2'b11, 6'b100000, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd0,  32'h00F0_1200});
        vecs.push_back('{"radd",  2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1,         6'd0,  32'h8000_0000});
        vecs.push_back('{"rsub",  2'b10, 6'b100010, 32'h0,         32'h1,         6'd0,  32'hFFFF_FFFF});
        vecs.push_back('{"and",   2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd0,  32'h0F00_0F00});
        vecs.push_back('{"or",    2'b10, 6'b100101, 32'hFF00_0000, 32'h0000_00FF, 6'd0,  32'hFF00_00FF});
        vecs.push_back('{"xor",   2'b10, 6'b100110, 32'hFFFF_0000, 32'hF0F0_F0F0, 6'd0,  32'h0F0F_F0F0});
        vecs.push_back('{"nor",   2'b10, 6'b100111, 32'hFFFF_0000, 32'h0000_FFFF, 6'd0,  32'h0});
        vecs.push_back('{"sll",   2'b10, 6'b000000, 32'h0,         32'h1,         6'd31, 32'h8000_0000});
        vecs.push_back('{"srl",   2'b10, 6'b000010, 32'h0,         32'h8000_0000, 6'd4,  32'h0800_0000});
        vecs.push_back('{"sra",   2'b10, 6'b000011, 32'h0,         32'h8000_0000, 6'd4,  32'hF800_0000});
        vecs.push_back('{"badfn", 2'b10, 6'b111111, 32'hABCD_00FF, 32'h0F0F_0F0F, 6'd0,  32'h0B0D_000F});
        vecs.push_back('{"slt",   2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1,         6'd0,  32'h1});
        vecs.push_back('{"sltu",  2'b10, 6'b101011, 32'hFFFF_FFFF, 32'h1,         6'd0,  32'h0});
        foreach (vecs[i])
            run_alu(vecs[i].tag, vecs[i].op, vecs[i].fn, {32'd0, vecs[i].av}, {32'd0, vecs[i].bv},
                    vecs[i].sh, vecs[i].exp);

        @(posedge clk); #1;
        chk("hold.valid", bus32.out_valid, 1'b0);
        chk("hold.zero", bus32.zero, 1'b1);

        run_mdu("mult", 1'b0, 6'b011000, 64'hFFFF_FFFD, 64'd7, 32, 64'hFFFF_FFFF_FFFF_FFEB);
        run_alu("mfhi_after_mult", 2'b10, 6'b010000, 64'd0, 64'd0, 6'd0, 32'hFFFF_FFFF);
        run_alu("mflo", 2'b10, 6'b010010, 64'd0, 64'd0, 6'd0, 32'hFFFF_FFEB);
        run_alu("add_keeps_hilo", 2'b00, 6'd0, 64'd2, 64'd3, 6'd0, 32'd5);
        chk("hilo_unchanged", hilo(1'b0), 64'hFFFF_FFFF_FFFF_FFEB);

        run_mdu("div_neg",   1'b0, 6'b011010, 64'hFFFF_FFF9, 64'd2, 32, 64'hFFFF_FFFF_FFFF_FFFD);
        run_mdu("divu_by0",  1'b0, 6'b011011, 64'd5,         64'd0, 32, 64'h0000_0005_FFFF_FFFF);
        run_mdu("div_by0",   1'b0, 6'b011010, 64'hFFFF_FFFB, 64'd0, 32, 64'hFFFF_FFFB_FFFF_FFFF);
        run_mdu("divu",      1'b0, 6'b011011, 64'd100,       64'd7, 32, 64'h0000_0002_0000_000E);
        run_mdu("div_negb",  1'b0, 6'b011010, 64'd7, 64'hFFFF_FFFE, 32, 64'h0000_0001_FFFF_FFFD);
        run_mdu("multu",     1'b0, 6'b011001, 64'h1_0000,    64'h1_0000, 32, 64'h0000_0001_0000_0000);
        run_mdu("div_minneg", 1'b0, 6'b011010, 64'h8000_0000, 64'hFFFF_FFFF, 32, 64'h0000_0000_8000_0000);
        run_alu("mfhi_after_div", 2'b10, 6'b010000, 64'd0, 64'd0, 6'd0, 32'd0);

        issue(1'b1, 2'b10, 6'b000011, 64'h5A, 64'h80, 6'd7);
        chk("w8.sra.valid", bus8.out_valid, 1'b1);
        chk("w8.sra.result", res(1'b1), 64'hFF);
        run_mdu("w8.multu", 1'b1, 6'b011001, 64'hFF, 64'hFF, 8, 64'hFE01);
        run_mdu("w8.mult",  1'b1, 6'b011000, 64'h80, 64'h80, 8, 64'h4000);
        run_mdu("w8.div",   1'b1, 6'b011010, 64'h80, 64'hFF, 8, 64'h0080);

        issue(1'b0, 2'b10, 6'b011001, 64'd3, 64'd5, 6'd0);
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort.ready_in_reset", bus32.in_ready, 1'b0);
        @(posedge clk); #1;
        chk("abort.valid", bus32.out_valid, 1'b0);
        chk("abort.hilo", hilo(1'b0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort.ready_after", bus32.in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            if (bus32.out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort.no_valid", 64'(seen), 64'd0);
        run_alu("abort.mflo", 2'b10, 6'b010010, 64'd0, 64'd0, 6'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
